operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have: instr  in  32  instruction word from fetch.
REQ-004 SHALL have: instr_valid  in  1  instr is meaningful this cycle.
REQ-005 SHALL have: stall  in  1  hold the output register.
REQ-006 SHALL have: wb_en  in  1, wb_addr  in  5, wb_data  in  32  register-file write port.
REQ-007 SHALL have: op1  out  32, op2  out  32, sft_amt  out  5, con  out  3  ALU operands and operation select.
REQ-008 SHALL have: dest  out  5, dest_we  out  1, ex_valid  out  1, illegal  out  1  execute-stage control.
REQ-009 SHALL use one clock domain: clk, with synchronous active-low reset rst_n.

Function
REQ-010 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-011 SHALL write wb_data to wb_addr at a rising clk edge when wb_en=1, regardless of stall.
REQ-012 SHALL read rs=instr[25:21] and rt=instr[20:16] combinationally, then register the decoded results.
REQ-013 SHALL drive con as: ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, SLT=6; 7 is unused.
REQ-014 SHALL decode opcode 0 by funct:
- 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT: op1=R[rs], op2=R[rt], sft_amt=0, dest=instr[15:11].
- 0x00 SLL, 0x02 SRL: op1=0, op2=R[rt], sft_amt=instr[10:6], dest=instr[15:11].
REQ-015 SHALL decode I-type, with op1=R[rs], sft_amt=0, dest=rt:
- 0x08 ADDI: op2 = sign-extended instr[15:0], con=ADD.
- 0x0C ANDI: op2 = zero-extended instr[15:0], con=AND.
- 0x0D ORI: op2 = zero-extended instr[15:0], con=OR.
REQ-016 SHALL treat any other opcode or funct as illegal.
- Registered result: illegal=1, ex_valid=0, dest_we=0; op1, op2, sft_amt, con, dest = 0.
REQ-017 SHALL set dest_we=1 only for a legal instruction with dest != 0.
REQ-018 SHALL update all outputs one cycle after capture (latency 1) at each edge where stall=0.
REQ-019 SHALL hold every output unchanged at an edge where stall=1.
REQ-020 SHALL, when instr_valid=0 and stall=0, load a bubble: ex_valid=0, dest_we=0, illegal=0, data outputs 0.
REQ-021 SHALL, for a legal valid instruction, load ex_valid=1 and illegal=0.
REQ-022 illegal SHALL be a one-cycle pulse unless held by stall.

Reset
REQ-023 SHALL, at an edge with rst_n=0, clear all 32 registers and set every output to 0.
- Reset SHALL override stall and wb_en.
REQ-024 SHALL discard any capture in progress when reset is asserted mid-operation.
- The first edge with rst_n=1 SHALL behave as a normal cycle.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL control same-cycle write-through.
- Defined: when wb_en=1 and wb_addr equals rs (or rt), is nonzero, and the read happens in the same cycle, the read SHALL return wb_data.
- Not defined: such reads SHALL return the pre-write register value.

Verification
REQ-026 Reset, then ADDI r1,r0,-5 (0x2001FFFB) with valid=1 -> next cycle: op1=0, op2=0xFFFFFFFB, con=0, dest=1, dest_we=1, ex_valid=1.
REQ-027 Write r2=55 and r3=33 via wb, then SUB r4,r2,r3 (0x00432022) -> op1=55, op2=33, con=1, dest=4.
- Also: SLL r5,r3,2 (0x00032880) -> op1=0, op2=33, sft_amt=2, con=4.
REQ-028 Set wb_en=1, wb_addr=2, wb_data=7 in the same cycle as OR r6,r2,r0 -> op1=7 with REGFILE_BYPASS_EN, op1=55 without.
REQ-029 Hold stall=1 for 3 cycles while instr changes -> outputs frozen.
- Concurrent wb to r9 SHALL still land; a later read of r9 returns the written value.
REQ-030 Apply opcode 0x3F -> illegal=1 and ex_valid=0 for one cycle.
- Also: wb to r0 with 0xFFFFFFFF, then read r0 -> 0.
- Also: rst_n=0 mid-stream -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/operand_stage.sv
// -----------------------------------------------------------------------------
// operand_stage
//   Decode / operand-fetch stage. Holds a 32 x 32-bit register file and turns
//   one instruction word per cycle into registered ALU operands, an operation
//   select and execute-stage control.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset (clears register file and outputs)
//     instr        instruction word from fetch
//     instr_valid  instr is meaningful this cycle
//     stall        hold the output register (register-file writes still happen)
//     wb_en        register-file write enable
//     wb_addr      register-file write address
//     wb_data      register-file write data
//     op1, op2     ALU operands
//     sft_amt      shift amount
//     con          ALU operation (ADD=0 SUB=1 AND=2 OR=3 SLL=4 SRL=5 SLT=6)
//     dest         destination register
//     dest_we      destination write enable (legal instruction, dest != 0)
//     ex_valid     a legal instruction is presented to execute
//     illegal      the captured instruction was not decodable
//
//   Configuration
//     REGFILE_BYPASS_EN  when defined, a same-cycle write to a nonzero source
//                        register is forwarded to the read port.
// -----------------------------------------------------------------------------
module operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   input  logic        stall,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic [4:0]  sft_amt,
   output logic [2:0]  con,
   output logic [4:0]  dest,
   output logic        dest_we,
   output logic        ex_valid,
   output logic        illegal
);

   localparam logic [2:0] CON_ADD = 3'd0;
   localparam logic [2:0] CON_SUB = 3'd1;
   localparam logic [2:0] CON_AND = 3'd2;
   localparam logic [2:0] CON_OR  = 3'd3;
   localparam logic [2:0] CON_SLL = 3'd4;
   localparam logic [2:0] CON_SRL = 3'd5;
   localparam logic [2:0] CON_SLT = 3'd6;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   logic [31:0] regs_r [32];

   logic [5:0]  opcode_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic [4:0]  rd_s;
   logic [4:0]  shamt_s;
   logic [5:0]  funct_s;
   logic [31:0] rs_val_s;
   logic [31:0] rt_val_s;

   logic        legal_s;
   logic [31:0] dec_op1_s;
   logic [31:0] dec_op2_s;
   logic [4:0]  dec_sft_s;
   logic [2:0]  dec_con_s;
   logic [4:0]  dec_dest_s;

   assign opcode_s = instr[31:26];
   assign rs_s     = instr[25:21];
   assign rt_s     = instr[20:16];
   assign rd_s     = instr[15:11];
   assign shamt_s  = instr[10:6];
   assign funct_s  = instr[5:0];

   // Register file: reset clears everything; writes to r0 are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'd0;
         end
      end else if (wb_en && (wb_addr != 5'd0)) begin
         regs_r[wb_addr] <= wb_data;
      end
   end

   // Source operand read ports, r0 hardwired to zero, optional write-through.
   always_comb begin
      rs_val_s = 32'd0;
      rt_val_s = 32'd0;
      if (rs_s != 5'd0) begin
         rs_val_s = regs_r[rs_s];
      end else begin
         rs_val_s = 32'd0;
      end
      if (rt_s != 5'd0) begin
         rt_val_s = regs_r[rt_s];
      end else begin
         rt_val_s = 32'd0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wb_en && (wb_addr == rs_s) && (rs_s != 5'd0)) begin
         rs_val_s = wb_data;
      end else begin
         rs_val_s = rs_val_s;
      end
      if (wb_en && (wb_addr == rt_s) && (rt_s != 5'd0)) begin
         rt_val_s = wb_data;
      end else begin
         rt_val_s = rt_val_s;
      end
`endif
   end

   // Instruction decode into operands and operation select.
   always_comb begin
      legal_s    = 1'b0;
      dec_op1_s  = 32'd0;
      dec_op2_s  = 32'd0;
      dec_sft_s  = 5'd0;
      dec_con_s  = CON_ADD;
      dec_dest_s = 5'd0;
      case (opcode_s)
         OPC_RTYPE: begin
            case (funct_s)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                  legal_s    = 1'b1;
                  dec_op1_s  = rs_val_s;
                  dec_op2_s  = rt_val_s;
                  dec_dest_s = rd_s;
                  case (funct_s)
                     FN_SUB:  dec_con_s = CON_SUB;
                     FN_AND:  dec_con_s = CON_AND;
                     FN_OR:   dec_con_s = CON_OR;
                     FN_SLT:  dec_con_s = CON_SLT;
                     default: dec_con_s = CON_ADD;
                  endcase
               end
               FN_SLL, FN_SRL: begin
                  legal_s    = 1'b1;
                  dec_op2_s  = rt_val_s;
                  dec_sft_s  = shamt_s;
                  dec_dest_s = rd_s;
                  dec_con_s  = (funct_s == FN_SLL) ? CON_SLL : CON_SRL;
               end
               default: begin
                  legal_s = 1'b0;
               end
            endcase
         end
         OPC_ADDI: begin
            legal_s    = 1'b1;
            dec_op1_s  = rs_val_s;
            dec_op2_s  = {{16{instr[15]}}, instr[15:0]};
            dec_con_s  = CON_ADD;
            dec_dest_s = rt_s;
         end
         OPC_ANDI, OPC_ORI: begin
            legal_s    = 1'b1;
            dec_op1_s  = rs_val_s;
            dec_op2_s  = {16'd0, instr[15:0]};
            dec_con_s  = (opcode_s == OPC_ANDI) ? CON_AND : CON_OR;
            dec_dest_s = rt_s;
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
   end

   // Output register: reset clears, stall holds, otherwise load instr/bubble/illegal.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op1      <= 32'd0;
         op2      <= 32'd0;
         sft_amt  <= 5'd0;
         con      <= 3'd0;
         dest     <= 5'd0;
         dest_we  <= 1'b0;
         ex_valid <= 1'b0;
         illegal  <= 1'b0;
      end else if (!stall) begin
         if (instr_valid && legal_s) begin
            op1      <= dec_op1_s;
            op2      <= dec_op2_s;
            sft_amt  <= dec_sft_s;
            con      <= dec_con_s;
            dest     <= dec_dest_s;
            dest_we  <= (dec_dest_s != 5'd0);
            ex_valid <= 1'b1;
            illegal  <= 1'b0;
         end else begin
            // Bubble and illegal both zero the datapath; only illegal flags.
            op1      <= 32'd0;
            op2      <= 32'd0;
            sft_amt  <= 5'd0;
            con      <= 3'd0;
            dest     <= 5'd0;
            dest_we  <= 1'b0;
            ex_valid <= 1'b0;
            illegal  <= instr_valid;
         end
      end
   end

endmodule

// File: tb/tb_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_stage
//   Directed bench for operand_stage. A behavioural model (architectural
//   register array plus an instruction-class table) predicts the registered
//   outputs every cycle; directed steps also pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_operand_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        stall;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  sft_amt;
   logic [2:0]  con;
   logic [4:0]  dest;
   logic        dest_we;
   logic        ex_valid;
   logic        illegal;

   operand_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .op1         (op1),
      .op2         (op2),
      .sft_amt     (sft_amt),
      .con         (con),
      .dest        (dest),
      .dest_we     (dest_we),
      .ex_valid    (ex_valid),
      .illegal     (illegal)
   );

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  sft;
      logic [2:0]  con;
      logic [4:0]  dest;
      logic        we;
      logic        ev;
      logic        ill;
   } out_t;

   int          checks = 0;
   int          errors = 0;
   logic        check_en = 1'b0;
   logic [31:0] m_regs [32];
   out_t        exp_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Architectural read: r0 is zero; a same-cycle write is visible only with bypass.
   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (wb_en && wb_addr == a) return wb_data;
`endif
      return m_regs[a];
   endfunction

   // Instruction classes: 0 illegal, 1 reg-reg, 2 shift, 3 signed imm, 4 unsigned imm.
   function automatic out_t model_decode(input logic [31:0] ins, input logic [31:0] a,
                                         input logic [31:0] b);
      out_t o;
      int   kind;
      logic [2:0] c;
      o = '0;
      kind = 0;
      c = 3'd0;
      if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h20: begin kind = 1; c = 3'd0; end
            6'h22: begin kind = 1; c = 3'd1; end
            6'h24: begin kind = 1; c = 3'd2; end
            6'h25: begin kind = 1; c = 3'd3; end
            6'h2A: begin kind = 1; c = 3'd6; end
            6'h00: begin kind = 2; c = 3'd4; end
            6'h02: begin kind = 2; c = 3'd5; end
            default: kind = 0;
         endcase
      end else begin
         case (ins[31:26])
            6'h08: begin kind = 3; c = 3'd0; end
            6'h0C: begin kind = 4; c = 3'd2; end
            6'h0D: begin kind = 4; c = 3'd3; end
            default: kind = 0;
         endcase
      end
      case (kind)
         1: begin o.op1 = a; o.op2 = b; o.dest = ins[15:11]; end
         2: begin o.op2 = b; o.sft = ins[10:6]; o.dest = ins[15:11]; end
         3: begin o.op1 = a; o.op2 = {{16{ins[15]}}, ins[15:0]}; o.dest = ins[20:16]; end
         4: begin o.op1 = a; o.op2 = {16'd0, ins[15:0]}; o.dest = ins[20:16]; end
         default: o.ill = 1'b1;
      endcase
      if (kind != 0) begin
         o.con = c;
         o.ev  = 1'b1;
         o.we  = (o.dest != 5'd0);
      end
      return o;
   endfunction

   // Model update at each rising edge, from the inputs held stable since the last falling edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         exp_o = '0;
      end else begin
         if (!stall) begin
            if (instr_valid)
               exp_o = model_decode(instr, mread(instr[25:21]), mread(instr[20:16]));
            else
               exp_o = '0;
         end
         if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      end
   end

   // Every-cycle comparison of DUT against the model on the falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("m_op1",      op1,              exp_o.op1);
         chk("m_op2",      op2,              exp_o.op2);
         chk("m_sft_amt",  {27'd0, sft_amt}, {27'd0, exp_o.sft});
         chk("m_con",      {29'd0, con},     {29'd0, exp_o.con});
         chk("m_dest",     {27'd0, dest},    {27'd0, exp_o.dest});
         chk("m_dest_we",  {31'd0, dest_we}, {31'd0, exp_o.we});
         chk("m_ex_valid", {31'd0, ex_valid},{31'd0, exp_o.ev});
         chk("m_illegal",  {31'd0, illegal}, {31'd0, exp_o.ill});
      end
   end

   task automatic drive(input logic [31:0] i, input logic v, input logic s,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      instr       = i;
      instr_valid = v;
      stall       = s;
      wb_en       = we;
      wb_addr     = wa;
      wb_data     = wd;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check_en = 1'b1;
      chk("rst_op1", op1, 32'd0);
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);

      // ADDI r1,r0,-5
      rst_n = 1'b1;
      drive(32'h2001FFFB, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("addi_op1", op1, 32'd0);
      chk("addi_op2", op2, 32'hFFFFFFFB);
      chk("addi_con", {29'd0, con}, 32'd0);
      chk("addi_dest", {27'd0, dest}, 32'd1);
      chk("addi_we", {31'd0, dest_we}, 32'd1);
      chk("addi_ev", {31'd0, ex_valid}, 32'd1);

      drive(32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd55);
      @(negedge clk);
      chk("bubble_ev", {31'd0, ex_valid}, 32'd0);
      drive(32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd33);
      @(negedge clk);

      // SUB r4,r2,r3
      drive(32'h00432022, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("sub_op1", op1, 32'd55);
      chk("sub_op2", op2, 32'd33);
      chk("sub_con", {29'd0, con}, 32'd1);
      chk("sub_dest", {27'd0, dest}, 32'd4);

      // SLL r5,r3,2
      drive(32'h00032880, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("sll_op1", op1, 32'd0);
      chk("sll_op2", op2, 32'd33);
      chk("sll_sft", {27'd0, sft_amt}, 32'd2);
      chk("sll_con", {29'd0, con}, 32'd4);

      // OR r6,r2,r0 with concurrent write r2=7
      drive(32'h00403025, 1'b1, 1'b0, 1'b1, 5'd2, 32'd7);
      @(negedge clk);
`ifdef REGFILE_BYPASS_EN
      chk("or_bypass_op1", op1, 32'd7);
`else
      chk("or_nobypass_op1", op1, 32'd55);
`endif
      chk("or_con", {29'd0, con}, 32'd3);

      // ADD r7,r2,r3 then three stalled cycles with changing instr and a write to r9
      drive(32'h00433820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("add_op1", op1, 32'd7);
      drive(32'h00432022, 1'b1, 1'b1, 1'b1, 5'd9, 32'h12345678);
      @(negedge clk);
      chk("stall1_op1", op1, 32'd7);
      chk("stall1_dest", {27'd0, dest}, 32'd7);
      drive(32'hFC000000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("stall2_ill", {31'd0, illegal}, 32'd0);
      drive(32'h000377C2, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("stall3_ev", {31'd0, ex_valid}, 32'd1);
      chk("stall3_con", {29'd0, con}, 32'd0);

      // ORI r10,r9,0xF0 reads the write made during the stall
      drive(32'h352A00F0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("ori_op1", op1, 32'h12345678);
      chk("ori_op2", op2, 32'h000000F0);
      chk("ori_dest", {27'd0, dest}, 32'd10);

      // Illegal opcode pulses for exactly one cycle
      drive(32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("ill_flag", {31'd0, illegal}, 32'd1);
      chk("ill_ev", {31'd0, ex_valid}, 32'd0);
      drive(32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
      @(negedge clk);
      chk("ill_pulse_end", {31'd0, illegal}, 32'd0);

      // ADD r11,r0,r0 with another write to r0 in the same cycle
      drive(32'h00005820, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
      @(negedge clk);
      chk("r0_op1", op1, 32'd0);
      chk("r0_op2", op2, 32'd0);
      chk("r0_dest_we", {31'd0, dest_we}, 32'd1);

      // ANDI r12,r3,0x8001 / ADDI r13,r3,0x8001 / SRL r14,r3,31 / SLT r0,r2,r3 / bad funct
      drive(32'h306C8001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("andi_op2", op2, 32'h00008001);
      chk("andi_con", {29'd0, con}, 32'd2);
      drive(32'h206D8001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("addi_sext", op2, 32'hFFFF8001);
      drive(32'h000377C2, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("srl_sft", {27'd0, sft_amt}, 32'd31);
      chk("srl_con", {29'd0, con}, 32'd5);
      drive(32'h0043002A, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("slt_con", {29'd0, con}, 32'd6);
      chk("slt_dest_we", {31'd0, dest_we}, 32'd0);
      chk("slt_ev", {31'd0, ex_valid}, 32'd1);
      drive(32'h00430021, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("badfn_ill", {31'd0, illegal}, 32'd1);

      // Reset mid-stream overrides stall and write-back
      drive(32'h00433820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      drive(32'h00432022, 1'b1, 1'b1, 1'b1, 5'd9, 32'd5);
      @(negedge clk);
      chk("mrst_op1", op1, 32'd0);
      chk("mrst_ev", {31'd0, ex_valid}, 32'd0);
      chk("mrst_dest", {27'd0, dest}, 32'd0);
      rst_n = 1'b1;
      drive(32'h00433820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("post_rst_op1", op1, 32'd0);
      chk("post_rst_ev", {31'd0, ex_valid}, 32'd1);
      chk("post_rst_dest", {27'd0, dest}, 32'd7);
      drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
